seg_scan_serial_ctrl: RTL and testbench

//  Parametrised multiplexed 7-segment scan controller with serial (74HC595-style) segment output.

---
 rtl/seg_scan_serial_ctrl_pkg.sv | 48 ++++
 rtl/seg_scan_serial_ctrl_serializer.sv | 118 +++++++++++
 rtl/seg_scan_serial_ctrl.sv | 149 ++++++++++++++
 tb/tb_seg_scan_serial_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_serial_ctrl_pkg.sv
// Shared definitions for the serial 7-segment scan controller:
// hex font, the blank glyph and the FSM state encodings.
package seg_scan_serial_ctrl_pkg;

    // Active-high {dp,g,f,e,d,c,b,a} pattern with every segment dark.
    localparam logic [7:0] GLYPH_BLANK = 8'h00;

    // Scan sequencer: IDLE until the first slot tick, then LOAD/SHIFT/SHOW per slot.
    typedef enum logic [1:0] {
        SCAN_IDLE,
        SCAN_LOAD,
        SCAN_SHIFT,
        SCAN_SHOW
    } scan_state_e;

    // Serializer engine: low/high halves of each sr_clk period, then the latch strobe.
    typedef enum logic [1:0] {
        SER_IDLE,
        SER_SHIFT_LO,
        SER_SHIFT_HI,
        SER_LATCH
    } ser_state_e;

    // Hex font, active-high, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_scan_serial_ctrl_serializer.sv
// 74HC595-style shift/latch engine: shifts SEG_W bits MSB first with an
// sr_clk half-period of SCK_DIV cycles, then pulses sr_latch for SCK_DIV cycles.
// A start request restarts the engine from any state.
module seg_scan_serial_ctrl_serializer
    import seg_scan_serial_ctrl_pkg::*;
#(
    parameter int SEG_W   = 8,
    parameter int SCK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [SEG_W-1:0] data_i,
    output logic             busy_o,
    output logic             sr_clk_o,
    output logic             sr_data_o,
    output logic             sr_latch_o
);

    localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int BIT_W = (SEG_W > 1) ? $clog2(SEG_W) : 1;

    ser_state_e       state_q, state_d;
    logic [SEG_W-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             sck_q, sck_d;
    logic             sdo_q, sdo_d;
    logic             lat_q, lat_d;
    logic             div_end;

    // Next-state: advance phase every SCK_DIV cycles, present each bit on the falling half.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        div_d   = div_q;
        sck_d   = sck_q;
        sdo_d   = sdo_q;
        lat_d   = lat_q;
        div_end = (div_q == DIV_W'(SCK_DIV - 1));
        if (start_i) begin
            state_d = SER_SHIFT_LO;
            shreg_d = data_i;
            bit_d   = '0;
            div_d   = '0;
            sck_d   = 1'b0;
            sdo_d   = data_i[SEG_W-1];
            lat_d   = 1'b0;
        end else begin
            case (state_q)
                SER_SHIFT_LO: begin
                    if (div_end) begin
                        div_d   = '0;
                        sck_d   = 1'b1;
                        state_d = SER_SHIFT_HI;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                SER_SHIFT_HI: begin
                    if (div_end) begin
                        div_d = '0;
                        sck_d = 1'b0;
                        if (bit_q == BIT_W'(SEG_W - 1)) begin
                            lat_d   = 1'b1;
                            state_d = SER_LATCH;
                        end else begin
                            bit_d   = bit_q + 1'b1;
                            shreg_d = shreg_q << 1;
                            sdo_d   = shreg_q[SEG_W-2];
                            state_d = SER_SHIFT_LO;
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                SER_LATCH: begin
                    if (div_end) begin
                        div_d   = '0;
                        lat_d   = 1'b0;
                        state_d = SER_IDLE;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                default: state_d = SER_IDLE;
            endcase
        end
    end

    // State and registered pin drivers; reset drops every pin immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SER_IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            sck_q   <= 1'b0;
            sdo_q   <= 1'b0;
            lat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            sck_q   <= sck_d;
            sdo_q   <= sdo_d;
            lat_q   <= lat_d;
        end
    end

    assign busy_o     = (state_q != SER_IDLE);
    assign sr_clk_o   = sck_q;
    assign sr_data_o  = sdo_q;
    assign sr_latch_o = lat_q;

endmodule

// File: rtl/seg_scan_serial_ctrl.sv
// Multiplexed 7-segment scan controller with serial segment output.
// Each SCAN_DIV-cycle slot loads one digit's glyph, shifts it out, latches it,
// then drives that digit's enable (PWM-gated) for the rest of the slot.
module seg_scan_serial_ctrl
    import seg_scan_serial_ctrl_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int SEG_W          = 8,
    parameter int SCAN_DIV       = 50000,
    parameter int SCK_DIV        = 4,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        power_on,
    input  logic [4*N_DIGITS-1:0]       digit_code,
    input  logic [N_DIGITS-1:0]         dp_mask,
    input  logic [N_DIGITS-1:0]         blank_mask,
    input  logic                        lz_blank,
    input  logic [3:0]                  bright,
    output logic                        sr_clk,
    output logic                        sr_data,
    output logic                        sr_latch,
    output logic [N_DIGITS-1:0]         digit_enable,
    output logic [$clog2(N_DIGITS)-1:0] slot_idx,
    output logic                        frame_done
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int CNT_W = $clog2(SCAN_DIV);

    if (N_DIGITS < 2) begin : g_chk_digits
        $error("seg_scan_serial_ctrl: N_DIGITS must be >= 2");
    end
    if (SEG_W < 8) begin : g_chk_segw
        $error("seg_scan_serial_ctrl: SEG_W must hold {dp,g..a}");
    end
    if (SCK_DIV < 1) begin : g_chk_sck
        $error("seg_scan_serial_ctrl: SCK_DIV must be >= 1");
    end
    if (SCAN_DIV < 2*SCK_DIV*SEG_W + SCK_DIV + 4) begin : g_chk_scan
        $error("seg_scan_serial_ctrl: SCAN_DIV too short for shift and latch");
    end

    scan_state_e         state_q, state_d;
    logic [CNT_W-1:0]    slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]    slot_idx_q, slot_idx_d;
    logic                frame_done_q, frame_done_d;
    logic [3:0]          pwm_q, pwm_d;
    logic [N_DIGITS-1:0] digit_en_q, digit_en_d;
    logic                tick;

    logic [3:0]          nib;
    logic                dp_sel, blk_sel, lz_run, lz_hit, glyph_blank;
    logic [7:0]          seg_raw;
    logic [SEG_W-1:0]    glyph;
    logic                ser_start, ser_busy;

    // Glyph for the current slot. Digit 0 is the leftmost, held in the top nibble;
    // lz_run stays set while every digit from the left up to i is zero.
    always_comb begin
        nib     = 4'h0;
        dp_sel  = 1'b0;
        blk_sel = 1'b0;
        lz_run  = 1'b1;
        lz_hit  = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (digit_code[4*(N_DIGITS-1-i) +: 4] != 4'h0) lz_run = 1'b0;
            if (slot_idx_q == IDX_W'(i)) begin
                nib     = digit_code[4*(N_DIGITS-1-i) +: 4];
                dp_sel  = dp_mask[i];
                blk_sel = blank_mask[i];
                lz_hit  = lz_run && (i < N_DIGITS - 1);
            end
        end
        glyph_blank = !power_on || blk_sel || (lz_blank && lz_hit);
        seg_raw     = glyph_blank ? GLYPH_BLANK : {dp_sel, hex_font(nib)};
        glyph       = (SEG_ACTIVE_LOW != 0) ? ~SEG_W'(seg_raw) : SEG_W'(seg_raw);
    end

    // Slot timing, scan FSM and the anti-ghost / PWM gated digit drive.
    always_comb begin
        tick         = (slot_cnt_q == CNT_W'(SCAN_DIV - 1));
        slot_cnt_d   = tick ? '0 : slot_cnt_q + 1'b1;
        slot_idx_d   = slot_idx_q;
        // The first tick out of IDLE shows slot 0 rather than skipping it.
        if (tick && state_q != SCAN_IDLE) begin
            slot_idx_d = (slot_idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : slot_idx_q + 1'b1;
        end
        frame_done_d = tick && (slot_idx_q == IDX_W'(N_DIGITS - 1));
        pwm_d        = pwm_q + 1'b1;
        state_d      = state_q;
        case (state_q)
            SCAN_IDLE:  if (tick) state_d = SCAN_LOAD;
            SCAN_LOAD:  state_d = tick ? SCAN_LOAD : SCAN_SHIFT;
            SCAN_SHIFT: begin
                // A tick here only happens with illegal timing; restart the slot cleanly.
                if (tick)           state_d = SCAN_LOAD;
                else if (!ser_busy) state_d = SCAN_SHOW;
            end
            SCAN_SHOW:  if (tick) state_d = SCAN_LOAD;
            default:    state_d = SCAN_IDLE;
        endcase
        digit_en_d = '0;
        if (state_d == SCAN_SHOW && power_on && pwm_q <= bright) begin
            digit_en_d = N_DIGITS'(1) << slot_idx_d;
        end
    end

    // Control registers; all outputs are registered so reset clears them at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SCAN_IDLE;
            slot_cnt_q   <= '0;
            slot_idx_q   <= '0;
            frame_done_q <= 1'b0;
            pwm_q        <= 4'h0;
            digit_en_q   <= '0;
        end else begin
            state_q      <= state_d;
            slot_cnt_q   <= slot_cnt_d;
            slot_idx_q   <= slot_idx_d;
            frame_done_q <= frame_done_d;
            pwm_q        <= pwm_d;
            digit_en_q   <= digit_en_d;
        end
    end

    assign ser_start = (state_q == SCAN_LOAD);

    seg_scan_serial_ctrl_serializer #(
        .SEG_W   (SEG_W),
        .SCK_DIV (SCK_DIV)
    ) u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (ser_start),
        .data_i     (glyph),
        .busy_o     (ser_busy),
        .sr_clk_o   (sr_clk),
        .sr_data_o  (sr_data),
        .sr_latch_o (sr_latch)
    );

    assign digit_enable = digit_en_q;
    assign slot_idx     = slot_idx_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_seg_scan_serial_ctrl.sv
// Bench for seg_scan_serial_ctrl with 4 digits, SCAN_DIV=200, SCK_DIV=2.
// Expected shifted bytes come from an independent active-low font model and
// are queued when inputs are driven, then popped as each latch strobe appears.
module tb_seg_scan_serial_ctrl;

    localparam int N  = 4;
    localparam int SD = 200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        power_on;
    logic [15:0] digit_code;
    logic [3:0]  dp_mask, blank_mask;
    logic        lz_blank;
    logic [3:0]  bright;
    logic        sr_clk, sr_data, sr_latch;
    logic [3:0]  digit_enable;
    logic [1:0]  slot_idx;
    logic        frame_done;

    typedef struct {
        logic [7:0] byte_v;
        logic [1:0] idx;
        logic [3:0] en;
        bit         chk_en;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seg_scan_serial_ctrl #(
        .N_DIGITS(N), .SEG_W(8), .SCAN_DIV(SD), .SCK_DIV(2), .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .power_on(power_on), .digit_code(digit_code),
        .dp_mask(dp_mask), .blank_mask(blank_mask), .lz_blank(lz_blank), .bright(bright),
        .sr_clk(sr_clk), .sr_data(sr_data), .sr_latch(sr_latch),
        .digit_enable(digit_enable), .slot_idx(slot_idx), .frame_done(frame_done)
    );

    // At most one digit may ever be driven.
    always @(negedge clk) begin
        if (rst_n && !$onehot0(digit_enable)) begin
            errors++;
            $display("FAIL onehot0: digit_enable=%b, required at most one bit set", digit_enable);
        end
    end

    // Safety net so the run always ends with a summary.
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    function automatic logic [7:0] ref_font_al(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
            4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
            4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
            4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
        endcase
    endfunction

    // Expected active-low byte for digit i under the currently driven inputs.
    function automatic logic [7:0] model_byte(input int i);
        logic [3:0] nb;
        bit         all_zero;
        nb = digit_code[4*(3-i) +: 4];
        all_zero = 1'b1;
        for (int j = 0; j <= i; j++) if (digit_code[4*(3-j) +: 4] != 4'h0) all_zero = 1'b0;
        if (!power_on || blank_mask[i] || (lz_blank && i < 3 && all_zero)) return 8'hFF;
        return dp_mask[i] ? (ref_font_al(nb) & 8'h7F) : ref_font_al(nb);
    endfunction

    task automatic push_slot(input int i, input bit chk_en);
        exp_t e;
        e.byte_v = model_byte(i);
        e.idx    = 2'(i);
        e.en     = power_on ? 4'(1 << i) : 4'b0000;
        e.chk_en = chk_en;
        sb_q.push_back(e);
    endtask

    task automatic push_frame(input bit chk_en);
        for (int i = 0; i < N; i++) push_slot(i, chk_en);
    endtask

    // Bounded wait for a fresh frame_done pulse (next LOAD is slot 0).
    task automatic wait_frame(output bit to);
        int cyc;
        to = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!frame_done && cyc < 4000);
        if (!frame_done) to = 1'b1;
    endtask

    // Records one slot's serial transfer: bits on sr_clk rises up to the latch,
    // the slot index during the latch, latch length, and enable early in SHOW.
    task automatic capture_slot(output logic [7:0] b, output int nbits, output logic [1:0] idx,
                                output logic [3:0] en, output logic ghost, output int lat,
                                output bit to);
        logic prev_sck;
        int   cyc;
        b = 8'h00; nbits = 0; idx = 2'b00; en = 4'b0000; ghost = 1'b0; lat = 0; to = 1'b0;
        cyc = 0;
        prev_sck = sr_clk;
        forever begin
            @(negedge clk);
            cyc++;
            if (sr_clk && !prev_sck) begin
                b = {b[6:0], sr_data};
                nbits++;
            end
            prev_sck = sr_clk;
            if ((nbits > 0 || sr_latch) && digit_enable != 4'b0000) ghost = 1'b1;
            if (sr_latch) break;
            if (cyc > 4000) begin
                to = 1'b1;
                break;
            end
        end
        idx = slot_idx;
        cyc = 0;
        while (sr_latch && cyc < 100) begin
            lat++;
            @(negedge clk);
            if (sr_latch && digit_enable != 4'b0000) ghost = 1'b1;
            cyc++;
        end
        if (sr_latch) to = 1'b1;
        @(negedge clk);
        @(negedge clk);
        en = digit_enable;
    endtask

    task automatic test_reset();
        logic [7:0] b; int nb; logic [1:0] idx; logic [3:0] en; logic gh; int lat; bit to;
        exp_t e;
        rst_n = 1'b0; power_on = 1'b1; digit_code = 16'h1234; dp_mask = 4'b0000;
        blank_mask = 4'b0000; lz_blank = 1'b0; bright = 4'hF;
        repeat (3) @(negedge clk);
        checks++; if (sr_clk !== 1'b0) begin errors++; $display("FAIL reset_sr_clk: got %b want 0", sr_clk); end
        checks++; if (sr_data !== 1'b0) begin errors++; $display("FAIL reset_sr_data: got %b want 0", sr_data); end
        checks++; if (sr_latch !== 1'b0) begin errors++; $display("FAIL reset_sr_latch: got %b want 0", sr_latch); end
        checks++; if (digit_enable !== 4'b0000) begin errors++; $display("FAIL reset_enable: got %b want 0000", digit_enable); end
        checks++; if (slot_idx !== 2'd0) begin errors++; $display("FAIL reset_slot_idx: got %0d want 0", slot_idx); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        rst_n = 1'b1;
        push_slot(0, 1'b1);
        capture_slot(b, nb, idx, en, gh, lat, to);
        e = sb_q.pop_front();
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL reset_first_slot: timeout got 1 want 0"); end
        checks++; if (b !== e.byte_v) begin errors++; $display("FAIL reset_first_byte: got %h want %h", b, e.byte_v); end
        checks++; if (idx !== e.idx) begin errors++; $display("FAIL reset_first_idx: got %0d want %0d", idx, e.idx); end
        checks++; if (en !== e.en) begin errors++; $display("FAIL reset_first_en: got %b want %b", en, e.en); end
    endtask

    task automatic test_hex_decode();
        logic [7:0] b; int nb; logic [1:0] idx; logic [3:0] en; logic gh; int lat; bit to;
        exp_t e;
        digit_code = 16'h1234; lz_blank = 1'b0; dp_mask = 4'b0000; blank_mask = 4'b0000;
        push_frame(1'b1);
        wait_frame(to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL hex_frame_wait: timeout got 1 want 0"); end
        for (int k = 0; k < N; k++) begin
            capture_slot(b, nb, idx, en, gh, lat, to);
            e = sb_q.pop_front();
            checks++; if (to !== 1'b0) begin errors++; $display("FAIL hex_timeout slot%0d: got 1 want 0", k); end
            checks++; if (b !== e.byte_v) begin errors++; $display("FAIL hex_byte slot%0d: got %h want %h", k, b, e.byte_v); end
            checks++; if (nb !== 8) begin errors++; $display("FAIL hex_nbits slot%0d: got %0d want 8", k, nb); end
            checks++; if (lat !== 2) begin errors++; $display("FAIL hex_latch_len slot%0d: got %0d want 2", k, lat); end
            checks++; if (idx !== e.idx) begin errors++; $display("FAIL hex_idx slot%0d: got %0d want %0d", k, idx, e.idx); end
            checks++; if (gh !== 1'b0) begin errors++; $display("FAIL hex_ghost slot%0d: got enable during shift", k); end
            checks++; if (en !== e.en) begin errors++; $display("FAIL hex_enable slot%0d: got %b want %b", k, en, e.en); end
        end
    endtask

    task automatic test_leading_zero();
        logic [15:0] codes [3];
        logic [7:0] b; int nb; logic [1:0] idx; logic [3:0] en; logic gh; int lat; bit to;
        exp_t e;
        codes[0] = 16'h0007; codes[1] = 16'h0000; codes[2] = 16'h0100;
        lz_blank = 1'b1; dp_mask = 4'b0000; blank_mask = 4'b0000;
        for (int p = 0; p < 3; p++) begin
            digit_code = codes[p];
            push_frame(1'b1);
            wait_frame(to);
            checks++; if (to !== 1'b0) begin errors++; $display("FAIL lz_frame_wait: timeout got 1 want 0"); end
            for (int k = 0; k < N; k++) begin
                capture_slot(b, nb, idx, en, gh, lat, to);
                e = sb_q.pop_front();
                checks++; if (b !== e.byte_v) begin errors++; $display("FAIL lz_byte code=%h slot%0d: got %h want %h", codes[p], k, b, e.byte_v); end
                checks++; if (idx !== e.idx) begin errors++; $display("FAIL lz_idx slot%0d: got %0d want %0d", k, idx, e.idx); end
                checks++; if (en !== e.en) begin errors++; $display("FAIL lz_enable slot%0d: got %b want %b", k, en, e.en); end
            end
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_dp_blank();
        logic [3:0] dps [2];
        logic [7:0] b; int nb; logic [1:0] idx; logic [3:0] en; logic gh; int lat; bit to;
        exp_t e;
        dps[0] = 4'b0100; dps[1] = 4'b0101;
        digit_code = 16'h1234; blank_mask = 4'b0001; lz_blank = 1'b0;
        for (int p = 0; p < 2; p++) begin
            dp_mask = dps[p];
            push_frame(1'b1);
            wait_frame(to);
            checks++; if (to !== 1'b0) begin errors++; $display("FAIL dp_frame_wait: timeout got 1 want 0"); end
            for (int k = 0; k < N; k++) begin
                capture_slot(b, nb, idx, en, gh, lat, to);
                e = sb_q.pop_front();
                checks++; if (b !== e.byte_v) begin errors++; $display("FAIL dp_byte dp=%b slot%0d: got %h want %h", dps[p], k, b, e.byte_v); end
                checks++; if (en !== e.en) begin errors++; $display("FAIL dp_enable slot%0d: got %b want %b", k, en, e.en); end
            end
        end
        dp_mask = 4'b0000; blank_mask = 4'b0000;
    endtask

    task automatic test_pwm();
        logic [7:0] b; int nb; logic [1:0] idx; logic [3:0] en; logic gh; int lat; bit to;
        int hi, bad;
        exp_t e;
        digit_code = 16'h1234; bright = 4'd3;
        push_frame(1'b0);
        wait_frame(to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL pwm_frame_wait: timeout got 1 want 0"); end
        for (int k = 0; k < N; k++) begin
            capture_slot(b, nb, idx, en, gh, lat, to);
            e = sb_q.pop_front();
            checks++; if (b !== e.byte_v) begin errors++; $display("FAIL pwm_byte slot%0d: got %h want %h", k, b, e.byte_v); end
            checks++; if (gh !== 1'b0) begin errors++; $display("FAIL pwm_ghost slot%0d: got enable during shift", k); end
        end
        hi = 0; bad = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (digit_enable != 4'b0000) begin
                hi++;
                if (digit_enable !== 4'b1000) bad++;
            end
        end
        checks++; if (hi !== 16) begin errors++; $display("FAIL pwm_duty: got %0d of 64 cycles want 16", hi); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL pwm_digit: got %0d wrong-digit cycles want 0", bad); end
        bright = 4'hF;
    endtask

    task automatic test_power_off();
        logic [7:0] b; int nb; logic [1:0] idx; logic [3:0] en; logic gh; int lat; bit to;
        int n;
        exp_t e;
        digit_code = 16'h1234; power_on = 1'b1; bright = 4'hF;
        push_slot(0, 1'b1);
        wait_frame(to);
        capture_slot(b, nb, idx, en, gh, lat, to);
        e = sb_q.pop_front();
        checks++; if (en !== e.en) begin errors++; $display("FAIL pwroff_pre_enable: got %b want %b", en, e.en); end
        power_on = 1'b0;
        @(negedge clk);
        checks++; if (digit_enable !== 4'b0000) begin errors++; $display("FAIL pwroff_drop: got %b want 0000", digit_enable); end
        push_frame(1'b1);
        wait_frame(to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL pwroff_frame_wait: timeout got 1 want 0"); end
        for (int k = 0; k < N; k++) begin
            capture_slot(b, nb, idx, en, gh, lat, to);
            e = sb_q.pop_front();
            checks++; if (b !== e.byte_v) begin errors++; $display("FAIL pwroff_byte slot%0d: got %h want %h", k, b, e.byte_v); end
            checks++; if (en !== e.en) begin errors++; $display("FAIL pwroff_enable slot%0d: got %b want %b", k, en, e.en); end
        end
        wait_frame(to);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 4000);
        checks++; if (n !== 4*SD) begin errors++; $display("FAIL pwroff_frame_period: got %0d want %0d", n, 4*SD); end
        power_on = 1'b1;
    endtask

    task automatic test_async_reset();
        logic [7:0] b; int nb; logic [1:0] idx; logic [3:0] en; logic gh; int lat; bit to;
        int cyc;
        exp_t e;
        digit_code = 16'h1234;
        wait_frame(to);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!sr_clk && cyc < 1000);
        checks++; if (sr_clk !== 1'b1) begin errors++; $display("FAIL arst_find_hi: got sr_clk=%b want 1", sr_clk); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (sr_clk !== 1'b0) begin errors++; $display("FAIL arst_sr_clk: got %b want 0", sr_clk); end
        checks++; if (sr_latch !== 1'b0) begin errors++; $display("FAIL arst_sr_latch: got %b want 0", sr_latch); end
        checks++; if (digit_enable !== 4'b0000) begin errors++; $display("FAIL arst_enable: got %b want 0000", digit_enable); end
        checks++; if (slot_idx !== 2'd0) begin errors++; $display("FAIL arst_slot_idx: got %0d want 0", slot_idx); end
        repeat (3) @(negedge clk);
        digit_code = 16'hABCD;
        rst_n = 1'b1;
        push_slot(0, 1'b1);
        capture_slot(b, nb, idx, en, gh, lat, to);
        e = sb_q.pop_front();
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL arst_restart: timeout got 1 want 0"); end
        checks++; if (b !== e.byte_v) begin errors++; $display("FAIL arst_byte: got %h want %h", b, e.byte_v); end
        checks++; if (idx !== e.idx) begin errors++; $display("FAIL arst_idx: got %0d want %0d", idx, e.idx); end
        checks++; if (en !== e.en) begin errors++; $display("FAIL arst_enable: got %b want %b", en, e.en); end
        checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size()); end
    endtask

    initial begin
        test_reset();
        test_hex_decode();
        test_leading_zero();
        test_dp_blank();
        test_pwm();
        test_power_off();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
